// File: rtl/read_multi_pkg.sv
// Shared definitions for the multi-channel read engine: controller states
// and the iteration-mode encoding seen on the mode input.
package read_multi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic MODE_REPEAT = 1'b0;
  localparam logic MODE_LINEAR = 1'b1;

endpackage

// File: rtl/read_fifo.sv
// Synchronous output FIFO for the read engine. Holds the concatenated
// channel words between the memory return path and the consumer. The head
// reads as zero while empty so the output bus is quiet between jobs.
module read_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         data_in,
  output logic [WIDTH-1:0]         data_out,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int PtrWidth   = $clog2(DEPTH);
  localparam int CountWidth = PtrWidth + 1;

  logic [WIDTH-1:0]      r_mem [DEPTH];
  logic [PtrWidth-1:0]   r_wrPtr;
  logic [PtrWidth-1:0]   r_rdPtr;
  logic [CountWidth-1:0] r_count;
  logic                  w_full;
  logic                  w_doPush;
  logic                  w_doPop;

  // Qualify push/pop against occupancy; a push into a full FIFO is only
  // accepted when a pop frees the slot in the same cycle.
  always_comb begin
    w_full   = (r_count == CountWidth'(DEPTH));
    w_doPop  = pop && (r_count != '0);
    w_doPush = push && (!w_full || w_doPop);
  end

  // Storage array; flush only moves the pointers, stale data is never read.
  always_ff @(posedge clk) begin
    if (w_doPush && !flush) begin
      r_mem[r_wrPtr] <= data_in;
    end
  end

  // Pointer and occupancy bookkeeping; flush wins over push and pop.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) begin
        r_wrPtr <= r_wrPtr + PtrWidth'(1);
      end
      if (w_doPop) begin
        r_rdPtr <= r_rdPtr + PtrWidth'(1);
      end
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + CountWidth'(1);
        2'b01:   r_count <= r_count - CountWidth'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign empty    = (r_count == '0);
  assign count    = r_count;
  assign data_out = empty ? '0 : r_mem[r_rdPtr];

endmodule

// File: rtl/read_multi.sv
// Multi-channel read engine. Walks NUM_CHANNELS memories in lockstep with a
// shared offset, one read per cycle while the output FIFO has room for every
// outstanding return, and delivers concatenated words under valid/avail.
module read_multi
  import read_multi_pkg::*;
#(
  parameter int NUM_CHANNELS           = 2,
  parameter int DATA_WIDTH             = 16,
  parameter int LOG_MAX_ITERS          = 16,
  parameter int LOG_MAX_READS_PER_ITER = 16,
  parameter int LOG_MAX_ADDRESS        = 16,
  parameter int READ_LATENCY           = 1,
  parameter int FIFO_DEPTH             = 4
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    configure,
  input  logic                                    mode,
  input  logic [LOG_MAX_ITERS-1:0]                num_iters,
  input  logic [LOG_MAX_READS_PER_ITER-1:0]       num_reads_per_iter,
  input  logic [LOG_MAX_ADDRESS*NUM_CHANNELS-1:0] base_address,
  input  logic [LOG_MAX_ADDRESS-1:0]              stride,
  output logic [LOG_MAX_ADDRESS*NUM_CHANNELS-1:0] address_out,
  output logic                                    read,
  input  logic [DATA_WIDTH*NUM_CHANNELS-1:0]      data_in,
  output logic                                    valid_out,
  output logic [DATA_WIDTH*NUM_CHANNELS-1:0]      data_out,
  input  logic                                    avail_in,
  output logic                                    busy,
  output logic                                    done
);

  localparam int CountWidth   = $clog2(FIFO_DEPTH) + 1;
  localparam int SumWidth     = CountWidth + 1;
  localparam int AddrBusWidth = LOG_MAX_ADDRESS * NUM_CHANNELS;
  localparam int DataBusWidth = DATA_WIDTH * NUM_CHANNELS;

  // Latched job description
  state_t                              r_state;
  logic                                r_mode;
  logic [LOG_MAX_ITERS-1:0]            r_numIters;
  logic [LOG_MAX_READS_PER_ITER-1:0]   r_numReads;
  logic [AddrBusWidth-1:0]             r_base;
  logic [LOG_MAX_ADDRESS-1:0]          r_stride;

  // Walk position
  logic [LOG_MAX_ADDRESS-1:0]          r_offset;
  logic [LOG_MAX_READS_PER_ITER-1:0]   r_readCount;
  logic [LOG_MAX_ITERS-1:0]            r_iterCount;

  // Memory side and return tracking
  logic                                r_read;
  logic [AddrBusWidth-1:0]             r_address;
  logic [READ_LATENCY-1:0]             r_tag;
  logic [CountWidth-1:0]               r_inflight;

  // Effective values: the live config inputs on a configure cycle so the
  // first read can go out on the same edge, otherwise the latched state.
  logic                                w_mode;
  logic [LOG_MAX_ITERS-1:0]            w_numIters;
  logic [LOG_MAX_READS_PER_ITER-1:0]   w_numReads;
  logic [AddrBusWidth-1:0]             w_base;
  logic [LOG_MAX_ADDRESS-1:0]          w_stride;
  logic [LOG_MAX_ADDRESS-1:0]          w_offset;
  logic [LOG_MAX_READS_PER_ITER-1:0]   w_readCount;
  logic [LOG_MAX_ITERS-1:0]            w_iterCount;

  logic [AddrBusWidth-1:0]             w_address;
  logic                                w_zeroLen;
  logic                                w_space;
  logic                                w_lastRead;
  logic                                w_lastIter;
  logic                                w_issue;
  logic                                w_push;
  logic                                w_pop;
  logic                                w_drained;
  logic [CountWidth-1:0]               w_fifoCount;
  logic                                w_fifoEmpty;
  state_t                              w_nextState;

  // Select between live config (restart) and latched job state.
  always_comb begin
    if (configure) begin
      w_mode      = mode;
      w_numIters  = num_iters;
      w_numReads  = num_reads_per_iter;
      w_base      = base_address;
      w_stride    = stride;
      w_offset    = '0;
      w_readCount = '0;
      w_iterCount = '0;
    end else begin
      w_mode      = r_mode;
      w_numIters  = r_numIters;
      w_numReads  = r_numReads;
      w_base      = r_base;
      w_stride    = r_stride;
      w_offset    = r_offset;
      w_readCount = r_readCount;
      w_iterCount = r_iterCount;
    end
  end

  // One adder per channel; the sum wraps naturally at the address width.
  genvar gc;
  generate
    for (gc = 0; gc < NUM_CHANNELS; gc++) begin : g_addr
      assign w_address[gc*LOG_MAX_ADDRESS +: LOG_MAX_ADDRESS] =
        w_base[gc*LOG_MAX_ADDRESS +: LOG_MAX_ADDRESS] + w_offset;
    end
  endgenerate

  // Issue decision, return-path push and consumer pop. A restart flushes the
  // FIFO and tags, so it always has room and suppresses push/pop.
  always_comb begin
    w_zeroLen  = (num_iters == '0) || (num_reads_per_iter == '0);
    w_space    = (SumWidth'(w_fifoCount) + SumWidth'(r_inflight)) < SumWidth'(FIFO_DEPTH);
    w_lastRead = (w_readCount == w_numReads - LOG_MAX_READS_PER_ITER'(1));
    w_lastIter = (w_iterCount == w_numIters - LOG_MAX_ITERS'(1));
    w_push     = r_tag[READ_LATENCY-1] && !configure;
    w_pop      = valid_out && avail_in && !configure;
    w_drained  = w_fifoEmpty && (r_inflight == '0);
    if (configure) begin
      w_issue = !w_zeroLen;
    end else begin
      w_issue = (r_state == RUN) && w_space;
    end
  end

  // Next state and completion pulse; a zero-length job passes through DRAIN
  // with nothing outstanding, so it completes on the following cycle.
  always_comb begin
    w_nextState = r_state;
    done        = 1'b0;
    if (configure) begin
      if (w_zeroLen || (w_lastRead && w_lastIter)) begin
        w_nextState = DRAIN;
      end else begin
        w_nextState = RUN;
      end
    end else begin
      case (r_state)
        RUN: begin
          if (w_issue && w_lastRead && w_lastIter) begin
            w_nextState = DRAIN;
          end
        end
        DRAIN: begin
          if (w_drained) begin
            w_nextState = IDLE;
            done        = 1'b1;
          end
        end
        default: w_nextState = r_state;
      endcase
    end
  end

  // Controller state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Capture the job description on every configure pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mode     <= MODE_REPEAT;
      r_numIters <= '0;
      r_numReads <= '0;
      r_base     <= '0;
      r_stride   <= '0;
    end else if (configure) begin
      r_mode     <= mode;
      r_numIters <= num_iters;
      r_numReads <= num_reads_per_iter;
      r_base     <= base_address;
      r_stride   <= stride;
    end
  end

  // Advance offset and read/iteration counters after each issued read;
  // REPEAT rewinds the offset at each iteration boundary.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_offset    <= '0;
      r_readCount <= '0;
      r_iterCount <= '0;
    end else if (w_issue) begin
      if (w_lastRead) begin
        r_readCount <= '0;
        r_iterCount <= w_iterCount + LOG_MAX_ITERS'(1);
        r_offset    <= (w_mode == MODE_REPEAT) ? '0 : w_offset + w_stride;
      end else begin
        r_readCount <= w_readCount + LOG_MAX_READS_PER_ITER'(1);
        r_iterCount <= w_iterCount;
        r_offset    <= w_offset + w_stride;
      end
    end else if (configure) begin
      r_offset    <= '0;
      r_readCount <= '0;
      r_iterCount <= '0;
    end
  end

  // Registered read strobe and per-channel addresses toward the memories.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_read    <= 1'b0;
      r_address <= '0;
    end else begin
      r_read <= w_issue;
      if (w_issue) begin
        r_address <= w_address;
      end
    end
  end

  // Tag pipeline marking the cycles where data_in carries a requested word;
  // clearing it on restart drops returns that belong to the aborted job.
  always_ff @(posedge clk) begin
    if (rst || configure) begin
      r_tag <= '0;
    end else begin
      r_tag <= (r_tag << 1) | READ_LATENCY'(r_read);
    end
  end

  // Outstanding reads: up on issue, down when the return lands in the FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_inflight <= '0;
    end else if (configure) begin
      r_inflight <= w_issue ? CountWidth'(1) : '0;
    end else begin
      case ({w_issue, w_push})
        2'b10:   r_inflight <= r_inflight + CountWidth'(1);
        2'b01:   r_inflight <= r_inflight - CountWidth'(1);
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  read_fifo #(
    .WIDTH (DataBusWidth),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (configure),
    .push     (w_push),
    .pop      (w_pop),
    .data_in  (data_in),
    .data_out (data_out),
    .count    (w_fifoCount),
    .empty    (w_fifoEmpty)
  );

  assign read        = r_read;
  assign address_out = r_address;
  assign valid_out   = !w_fifoEmpty;
  assign busy        = (r_state != IDLE);

endmodule

// File: tb/tb_read_multi.sv
// Self-checking bench for read_multi: a memory responder, a job-level
// reference model feeding address/data scoreboards, and a monitor that
// compares whatever the DUT presents against the queue heads.
module tb_read_multi;

   localparam int NCH   = 2;
   localparam int DW    = 16;
   localparam int AW    = 16;
   localparam int LI    = 16;
   localparam int LR    = 16;
   localparam int DEPTH = 4;

   logic                clk = 1'b0;
   logic                rst;
   logic                configure;
   logic                mode;
   logic [LI-1:0]       num_iters;
   logic [LR-1:0]       num_reads_per_iter;
   logic [AW*NCH-1:0]   base_address;
   logic [AW-1:0]       stride;
   logic [AW*NCH-1:0]   address_out;
   logic                read;
   logic [DW*NCH-1:0]   data_in;
   logic                valid_out;
   logic [DW*NCH-1:0]   data_out;
   logic                avail_in;
   logic                busy;
   logic                done;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   logic [AW*NCH-1:0] expAddr[$];
   logic [DW*NCH-1:0] expData[$];
   bit expectDone = 1'b0;
   bit zeroJob    = 1'b0;
   int configCyc  = 0;
   int lastPopCyc = 0;
   int readsSeen  = 0;
   int stallReads = 0;
   bit stallWatch = 1'b0;
   int doneCount  = 0;
   int availMode  = 0;

   read_multi #(
      .NUM_CHANNELS           (NCH),
      .DATA_WIDTH             (DW),
      .LOG_MAX_ITERS          (LI),
      .LOG_MAX_READS_PER_ITER (LR),
      .LOG_MAX_ADDRESS        (AW),
      .READ_LATENCY           (1),
      .FIFO_DEPTH             (DEPTH)
   ) dut (
      .clk                (clk),
      .rst                (rst),
      .configure          (configure),
      .mode               (mode),
      .num_iters          (num_iters),
      .num_reads_per_iter (num_reads_per_iter),
      .base_address       (base_address),
      .stride             (stride),
      .address_out        (address_out),
      .read               (read),
      .data_in            (data_in),
      .valid_out          (valid_out),
      .data_out           (data_out),
      .avail_in           (avail_in),
      .busy               (busy),
      .done               (done)
   );

   // Free-running clock
   always #5 clk = ~clk;

   // Cycle counter used to time done against the last pop or the configure edge
   always @(posedge clk) cyc <= cyc + 1;

   // Content of every memory location: a simple odd-multiplier hash per channel
   function automatic logic [DW-1:0] memWord(int c, logic [AW-1:0] a);
      return DW'(a * 7) ^ DW'(32'h1111 + c * 32'h3C5B);
   endfunction

   // Synchronous memories, one-cycle latency; garbage on cycles without a read
   always @(posedge clk) begin
      for (int c = 0; c < NCH; c++) begin
         data_in[c*DW +: DW] <= read ? memWord(c, address_out[c*AW +: AW]) : DW'($urandom);
      end
   end

   // Consumer readiness: 0 = always ready, 1 = random, 2 = stalled
   initial begin
      avail_in = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (availMode)
            0:       avail_in = 1'b1;
            1:       avail_in = ($urandom % 4) != 0;
            default: avail_in = 1'b0;
         endcase
      end
   end

   task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model: the full ordered list of addresses and returned words of a job
   task automatic loadJob(logic m, logic [LI-1:0] it, logic [LR-1:0] rd,
                          logic [AW*NCH-1:0] b, logic [AW-1:0] s);
      expAddr.delete();
      expData.delete();
      for (int i = 0; i < int'(it); i++) begin
         for (int r = 0; r < int'(rd); r++) begin
            int k;
            logic [AW-1:0]     off;
            logic [AW*NCH-1:0] a;
            logic [DW*NCH-1:0] d;
            k   = m ? (i * int'(rd) + r) : r;
            off = AW'(k * int'(s));
            for (int c = 0; c < NCH; c++) begin
               a[c*AW +: AW] = b[c*AW +: AW] + off;
               d[c*DW +: DW] = memWord(c, a[c*AW +: AW]);
            end
            expAddr.push_back(a);
            expData.push_back(d);
         end
      end
      zeroJob    = (it == '0) || (rd == '0);
      expectDone = 1'b1;
   endtask

   // Drive a configure pulse; the model is loaded at the edge that samples it
   task automatic applyStimulus(logic m, logic [LI-1:0] it, logic [LR-1:0] rd,
                                logic [AW*NCH-1:0] b, logic [AW-1:0] s);
      configure          = 1'b1;
      mode               = m;
      num_iters          = it;
      num_reads_per_iter = rd;
      base_address       = b;
      stride             = s;
      @(posedge clk);
      loadJob(m, it, rd, b, s);
      #1;
      configure = 1'b0;
      configCyc = cyc;
   endtask

   task automatic doReset();
      rst = 1'b1;
      @(posedge clk);
      expAddr.delete();
      expData.delete();
      expectDone = 1'b0;
      #1;
      rst = 1'b0;
   endtask

   task automatic checkResetOutputs(string tag);
      checkOutput({tag, "_read"},      32'(read),        32'd0);
      checkOutput({tag, "_addr"},      32'(address_out), 32'd0);
      checkOutput({tag, "_valid"},     32'(valid_out),   32'd0);
      checkOutput({tag, "_data"},      32'(data_out),    32'd0);
      checkOutput({tag, "_busy"},      32'(busy),        32'd0);
      checkOutput({tag, "_done"},      32'(done),        32'd0);
   endtask

   // Wait for the job's done pulse (bounded), then confirm the engine is idle
   task automatic waitIdle(int budget);
      int n = 0;
      while (expectDone && n < budget) begin
         @(posedge clk);
         n++;
      end
      if (expectDone) begin
         total++;
         bad++;
         $display("[TB] FAIL done_timeout actual=no_done required=done within %0d cycles", budget);
         expectDone = 1'b0;
      end else begin
         @(negedge clk);
         checkOutput("busy_after_done", 32'(busy), 32'd0);
         checkOutput("done_width",      32'(done), 32'd0);
      end
      @(posedge clk);
      #1;
   endtask

   // Monitor: compare presented addresses, FIFO head and done against the model
   always @(negedge clk) begin
      if (!rst) begin
         if (read) begin
            readsSeen++;
            if (stallWatch) stallReads++;
            if (expAddr.size() == 0) begin
               checkOutput("addr_unexpected_read", 32'(address_out), 32'hFFFF_FFFF);
            end else begin
               checkOutput("address", 32'(address_out), 32'(expAddr.pop_front()));
            end
         end
         if (valid_out) begin
            if (expData.size() == 0) begin
               checkOutput("data_unexpected_word", 32'(data_out), 32'hFFFF_FFFF);
            end else begin
               checkOutput("data_head", 32'(data_out), 32'(expData[0]));
               if (avail_in) begin
                  void'(expData.pop_front());
                  lastPopCyc = cyc;
               end
            end
         end
         if (done) begin
            doneCount++;
            checkOutput("done_expected", 32'(expectDone), 32'd1);
            if (expectDone) begin
               checkOutput("done_cycle", 32'(cyc), 32'(zeroJob ? configCyc : lastPopCyc + 1));
               checkOutput("words_left", 32'(expData.size()), 32'd0);
               checkOutput("addrs_left", 32'(expAddr.size()), 32'd0);
            end
            expectDone = 1'b0;
         end
      end
   end

   // Global watchdog so the run always terminates
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog actual=running required=finished");
      $fatal(1, "[TB] watchdog expired");
   end

   // Main stimulus sequence
   initial begin
      int dc;
      rst                = 1'b1;
      configure          = 1'b0;
      mode               = 1'b0;
      num_iters          = '0;
      num_reads_per_iter = '0;
      base_address       = '0;
      stride             = '0;
      repeat (2) @(posedge clk);
      doReset();
      @(negedge clk);
      checkResetOutputs("reset");
      @(posedge clk);
      #1;

      // Basic REPEAT walk, consumer always ready
      $display("[TB] basic repeat");
      applyStimulus(1'b0, 16'd2, 16'd3, {16'h0080, 16'h0010}, 16'd1);
      waitIdle(100);

      // LINEAR walk with wrap past the top of the address space
      $display("[TB] linear wrap");
      applyStimulus(1'b1, 16'd2, 16'd2, {16'h0100, 16'hFFF8}, 16'd4);
      waitIdle(100);

      // Backpressure: long stall mid-run must throttle reads and lose nothing
      $display("[TB] backpressure");
      applyStimulus(1'b1, 16'd1, 16'd16, {16'h0700, 16'h0300}, 16'd1);
      repeat (4) @(posedge clk);
      availMode = 2;
      repeat (5) @(posedge clk);
      stallReads = 0;
      stallWatch = 1'b1;
      repeat (15) @(posedge clk);
      stallWatch = 1'b0;
      checkOutput("stall_reads", 32'(stallReads), 32'd0);
      availMode = 0;
      waitIdle(200);

      // Zero-length jobs: no reads, done on the next cycle
      $display("[TB] zero length");
      readsSeen = 0;
      applyStimulus(1'b0, 16'd0, 16'd5, {16'h0020, 16'h0010}, 16'd1);
      waitIdle(20);
      applyStimulus(1'b1, 16'd3, 16'd0, {16'h0020, 16'h0010}, 16'd1);
      waitIdle(20);
      checkOutput("zero_len_reads", 32'(readsSeen), 32'd0);

      // Abort on the third read of a ten-read job, restart at base 0x40
      $display("[TB] abort");
      readsSeen = 0;
      applyStimulus(1'b1, 16'd1, 16'd10, {16'h0200, 16'h0000}, 16'd1);
      begin
         int n = 0;
         while (readsSeen < 2 && n < 50) begin
            @(posedge clk);
            n++;
         end
      end
      #1;
      applyStimulus(1'b0, 16'd1, 16'd4, {16'h0140, 16'h0040}, 16'd1);
      waitIdle(100);

      // Reset while two words sit in the FIFO: outputs clear, no done
      $display("[TB] reset mid drain");
      availMode = 2;
      applyStimulus(1'b1, 16'd1, 16'd2, {16'h0900, 16'h0500}, 16'd2);
      repeat (6) @(posedge clk);
      #1;
      dc = doneCount;
      doReset();
      @(negedge clk);
      checkResetOutputs("mid_reset");
      availMode = 0;
      repeat (5) @(posedge clk);
      checkOutput("no_done_after_reset", 32'(doneCount), 32'(dc));
      #1;

      // Randomized jobs with random backpressure and occasional restarts
      $display("[TB] random jobs");
      availMode = 1;
      for (int j = 0; j < 12; j++) begin
         applyStimulus(1'($urandom % 2), LI'($urandom_range(0, 3)), LR'($urandom_range(0, 5)),
                       {16'($urandom), 16'($urandom)},
                       (j % 2 == 1) ? 16'($urandom) : 16'($urandom_range(0, 8)));
         if (j % 3 == 1) begin
            repeat ($urandom_range(1, 6)) @(posedge clk);
            #1;
            applyStimulus(1'($urandom % 2), LI'($urandom_range(1, 3)), LR'($urandom_range(1, 5)),
                          {16'($urandom), 16'($urandom)}, 16'($urandom_range(0, 20)));
         end
         waitIdle(400);
      end
      availMode = 0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/read_multi.md
# read_multi

Parametrised multi-channel read engine that replaces the single-channel activation and weight readers in front of DISTRIBUTE_IN. On configuration it walks NUM_CHANNELS independent memories in lockstep, issuing one read per channel per cycle with a programmable stride and an iteration mode, buffering returned words in an output FIFO. It delivers the concatenated channel words under a valid/avail handshake with full backpressure, and signals `done` when the last word leaves.

## Interface
- NUM_CHANNELS, 2, number of memories read in lockstep
- DATA_WIDTH, 16, word width per channel (GROUP_SIZE*ACTIVATION_WIDTH)
- LOG_MAX_ITERS, 16, width of num_iters
- LOG_MAX_READS_PER_ITER, 16, width of num_reads_per_iter
- LOG_MAX_ADDRESS, 16, address width per channel
- READ_LATENCY, 1, cycles from `read` to valid `data_in` (MEM is synchronous)
- FIFO_DEPTH, 4, output FIFO entries (power of two, >= READ_LATENCY+2)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- configure  in  1  one-cycle start/restart pulse; samples all config inputs
- mode  in  1  0 = REPEAT (offset resets each iteration), 1 = LINEAR (offset continues)
- num_iters  in  LOG_MAX_ITERS  iterations
- num_reads_per_iter  in  LOG_MAX_READS_PER_ITER  reads per iteration
- base_address  in  LOG_MAX_ADDRESS*NUM_CHANNELS  per-channel base, channel c at bits [c*LOG_MAX_ADDRESS +: LOG_MAX_ADDRESS]
- stride  in  LOG_MAX_ADDRESS  address increment per read
- address_out  out  LOG_MAX_ADDRESS*NUM_CHANNELS  per-channel read address
- read  out  1  read strobe, shared by all channels
- data_in  in  DATA_WIDTH*NUM_CHANNELS  memory read data, channel c at [c*DATA_WIDTH +: DATA_WIDTH]
- valid_out  out  1  output word available
- data_out  out  DATA_WIDTH*NUM_CHANNELS  FIFO head, same packing
- avail_in  in  1  consumer accepts this cycle
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse at completion

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE + configure -> RUN. Latch config; zero offset, read count and iteration count.
- num_iters==0 or num_reads_per_iter==0: no reads are issued; `done` pulses the next cycle; return to IDLE.
- RUN: issue a read when fifo_count + inflight < FIFO_DEPTH, where inflight counts reads not yet returned.
  - On issue, address_c = base_c + offset. The sum wraps modulo 2^LOG_MAX_ADDRESS.
  - After issue, offset += stride.
  - After the num_reads_per_iter-th read of an iteration: iteration count++; in REPEAT mode offset returns to 0.
  - After the last read of the last iteration -> DRAIN.
- Return path: a READ_LATENCY-deep tag shift register marks valid `data_in` cycles. Each tagged cycle pushes one FIFO entry, inflight--.
- Output: valid_out = FIFO not empty. Pop when valid_out && avail_in. A push and a pop in the same cycle leave the count unchanged.
- DRAIN -> IDLE when the FIFO is empty, inflight==0 and no pop is pending. `done` pulses in the same cycle as the IDLE transition.
- configure in RUN/DRAIN aborts the current job:
  - FIFO flushed and tag register cleared; late `data_in` is discarded.
  - New parameters are latched and the engine restarts in RUN (or completes immediately if zero-length).
- configure has priority over a same-cycle pop or push.

## Timing
- Reset values: read=0, address_out=0, valid_out=0, data_out=0, busy=0, done=0. FIFO empty, state IDLE.
- read and address_out are registered.
- Latency, with configure sampled at edge E0:
  - read=1 during cycle E0+1.
  - data_in valid at E0+1+READ_LATENCY; pushed into the FIFO at that edge.
  - valid_out=1 one cycle later (E0+3 for READ_LATENCY=1).
- Throughput: one word per cycle with avail_in held high.
- Total words delivered = num_iters*num_reads_per_iter, in issue order.
- data_out holds stable while valid_out && !avail_in.

## Structure
- Package `read_multi_pkg`: state encoding (IDLE/RUN/DRAIN), mode constants (MODE_REPEAT=0, MODE_LINEAR=1).
- Sub-module `read_fifo`: synchronous FIFO.
  - Parameters DATA_WIDTH*NUM_CHANNELS and FIFO_DEPTH.
  - Ports push, pop, flush, count, empty.
  - When empty, data_out = head = 0.
- Top holds the FSM, counters, address adders per channel (generate loop) and the tag shift register.

## Test plan
- Basic REPEAT: NUM_CHANNELS=2, bases 0x10/0x80, stride 1, iters 2, reads 3, avail_in=1 -> addresses 0x10,11,12,10,11,12 (ch0) and 0x80,81,82,80,81,82 (ch1); 6 words out in order; done one cycle after the 6th pop.
- LINEAR with stride 4 and wrap: base 0xFFF8, iters 2, reads 2 -> ch0 addresses 0xFFF8, 0xFFFC, 0x0000, 0x0004.
- Backpressure: avail_in=0 for 20 cycles mid-run with FIFO_DEPTH=4 -> read stops once fifo_count+inflight=4; no word lost or duplicated; data_out stable while stalled.
- Zero-length: num_iters=0 -> read never asserted; done pulses at E0+1; busy stays 0 after done.
- Abort: configure at read #3 of a 10-read job with a new base 0x40 -> old returns are discarded; the first valid_out word comes from address 0x40.
- Reset mid-DRAIN: rst asserted with 2 words queued -> all outputs 0 the next cycle; no done pulse.
